ps2_key_ctrl: RTL and testbench
===============================

Name: ps2_key_ctrl

Overview:
Sequences the PS/2 receive path. It consumes the byte stream from ps2_rx (dout plus rx_done_tick) and owns that receiver's rx_en. It folds E0/F0 prefix bytes into single key events (code, extended, break) and hands each event downstream on a valid/ack handshake. A per-sequence watchdog discards half-received prefix sequences, replacing the free-running periodic receiver reset.

Parameters:
TIMEOUT_CYC, 2500000, clk cycles allowed between bytes of one prefixed sequence (50 ms at 50 MHz); must be at least 2.
FILTER_CTRL, 1, when 1, bytes AA/FA/EE/FE/00/FF received in IDLE are dropped instead of emitted.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  asynchronous, active-low reset.
enable  in  1  host enable for reception.
rx_done_tick  in  1  one-cycle strobe from ps2_rx; byte on rx_byte is valid.
rx_byte  in  8  scan byte from ps2_rx dout.
rx_en  out  1  receiver enable driven to ps2_rx.
key_code  out  8  scan code of the pending event.
key_ext  out  1  event was E0-prefixed.
key_break  out  1  event is a release (F0-prefixed).
key_valid  out  1  event pending; held until acknowledged.
key_ack  in  1  consumer accepts the pending event.
seq_err  out  1  one-cycle pulse: protocol error or watchdog timeout.
overrun  out  1  one-cycle pulse: event dropped because the previous event was still pending.

Behaviour:
- Reset (reset=0, async) sets: state IDLE, watchdog cleared, rx_en=0, key_valid=0, key_code=00, key_ext=0, key_break=0, seq_err=0, overrun=0.
- rx_en is a registered copy of enable (1-cycle latency). When enable=0, rx_done_tick is ignored and the FSM is forced to IDLE on the next edge. key_valid is not cleared by enable=0.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Transitions happen only on cycles with rx_done_tick=1:
  - IDLE: E0 -> GOT_E0. F0 -> GOT_F0. A filtered control byte stays in IDLE with no event. Any other byte emits (byte, ext=0, brk=0) and stays in IDLE.
  - GOT_E0: F0 -> GOT_E0F0. E0 stays in GOT_E0 (duplicate prefix tolerated). Any other byte emits (byte, 1, 0) and goes to IDLE.
  - GOT_F0: E0 or F0 pulses seq_err and goes to IDLE. Any other byte emits (byte, 0, 1) and goes to IDLE.
  - GOT_E0F0: E0 or F0 pulses seq_err and goes to IDLE. Any other byte emits (byte, 1, 1) and goes to IDLE.
- Watchdog:
  - Runs only in non-IDLE states.
  - Clears on every accepted rx_done_tick and on entry to IDLE.
  - Counts once per cycle otherwise.
  - When count reaches TIMEOUT_CYC-1: FSM goes to IDLE and seq_err pulses on the next cycle.
  - If a tick arrives in the same cycle as expiry, the tick wins and is processed normally.
- Emit latency: event outputs update on the edge after the rx_done_tick cycle.
- Handshake:
  - key_ack is sampled only while key_valid=1; key_valid falls on the edge after key_ack.
  - Emit while key_valid=0: load the event and set key_valid=1.
  - Emit in the same cycle as key_ack: load the new event and keep key_valid=1 (no bubble).
  - Emit while key_valid=1 and key_ack=0: the new event is discarded, the held event is unchanged, and overrun pulses.
- seq_err and overrun can pulse in the same cycle. Pulses are never stretched.
- Mid-sequence reset: the prefix is lost and the next byte is interpreted from IDLE.

Decomposition:
- Shared package ps2_pkg:
  - Scan constants: SC_EXT=E0, SC_BRK=F0, SC_BAT=AA, SC_ACK=FA, SC_ECHO=EE, SC_RESEND=FE, SC_ERR0=00, SC_ERR1=FF.
  - The 2-bit state encoding.
  - The watchdog width function, $clog2(TIMEOUT_CYC).
- Sub-module ps2_watchdog:
  - Ports: clk, reset, run, clear, expire.
  - Parameterised by TIMEOUT_CYC.
  - Instantiated once in ps2_key_ctrl.

Test Plan:
- Make and ack: enable=1; tick 1C -> next cycle key_valid=1, key_code=1C, ext=0, brk=0. ack -> key_valid=0 one cycle later.
- Extended break: ticks E0, F0, 75 (gaps under TIMEOUT) -> single event 75, ext=1, brk=1. No event after E0 or after F0.
- Timeout: TIMEOUT_CYC=16; tick F0, wait 15 cycles -> seq_err pulse and state IDLE. Then tick 1C -> make 1C, brk=0.
- Protocol error and filter: ticks F0, F0 -> seq_err, no event. Tick AA in IDLE -> no event (FILTER_CTRL=1). With FILTER_CTRL=0 -> event AA.
- Overrun and back-to-back: events 1C then 32 without ack -> key_code stays 1C, overrun pulse. Repeat with ack in the emit cycle -> key_code=32, key_valid stays 1.
- Reset and enable: assert reset after E0 -> all outputs zero. Release reset, tick 75 -> make 75, ext=0. Drop enable -> rx_en=0 one cycle later and ticks are ignored.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key controller slice.
//   - scan-code constants for prefix and controller-response bytes
//   - key-sequencer state encoding
//   - watchdog counter width helper and control-byte classifier
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_E0   = 2'd1,
    ST_GOT_F0   = 2'd2,
    ST_GOT_E0F0 = 2'd3
  } ps2_state_t;

  function automatic int unsigned wd_width(input int unsigned cyc);
    return $clog2(cyc);
  endfunction

  function automatic logic is_ctrl_byte(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_ECHO) ||
           (b == SC_RESEND) || (b == SC_ERR0) || (b == SC_ERR1);
  endfunction

endpackage

// File: rtl/ps2_watchdog.sv
// Inter-byte watchdog for prefixed PS/2 sequences.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   run    : count enable (sequencer is mid-sequence)
//   clear  : restart the count (byte accepted)
//   expire : high while the count sits at TIMEOUT_CYC-1 and run is set
module ps2_watchdog
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 2500000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int unsigned W = wd_width(TIMEOUT_CYC);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q;

  // Not running means idle, so the count is held at zero there; this covers
  // the "clear on entry to idle" case without a separate strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (!run || clear) begin
      cnt_q <= '0;
    end else if (cnt_q != LAST) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expire = run && (cnt_q == LAST);

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 key event sequencer.
// Folds E0/F0 prefix bytes from ps2_rx into single key events and presents
// them on a valid/ack handshake; a watchdog drops stalled prefix sequences.
//   clk, reset    : clock, asynchronous active-low reset
//   enable        : host reception enable; rx_en is its registered copy
//   rx_done_tick  : byte strobe from ps2_rx, rx_byte is the byte
//   key_code/ext/break/valid, key_ack : event output handshake
//   seq_err       : pulse on prefix protocol error or watchdog timeout
//   overrun       : pulse when an event is dropped because one is pending
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 2500000,
  parameter bit          FILTER_CTRL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_byte,
  output logic       rx_en,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       seq_err,
  output logic       overrun
);

  ps2_state_t state_q, state_d;
  logic       tick_ok;
  logic       wd_expire;
  logic       emit;
  logic       emit_ext;
  logic       emit_brk;
  logic       err_d;

  assign tick_ok = enable && rx_done_tick;

  ps2_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .run   (state_q != ST_IDLE),
    .clear (tick_ok),
    .expire(wd_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A byte arriving in the expiry cycle takes priority over the timeout.
  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    err_d    = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else if (tick_ok) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_byte == SC_EXT) begin
            state_d = ST_GOT_E0;
          end else if (rx_byte == SC_BRK) begin
            state_d = ST_GOT_F0;
          end else if (!(FILTER_CTRL && is_ctrl_byte(rx_byte))) begin
            emit = 1'b1;
          end
        end
        ST_GOT_E0: begin
          if (rx_byte == SC_BRK) begin
            state_d = ST_GOT_E0F0;
          end else if (rx_byte != SC_EXT) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          state_d = ST_IDLE;
          if (rx_byte == SC_EXT || rx_byte == SC_BRK) begin
            err_d = 1'b1;
          end else begin
            emit     = 1'b1;
            emit_brk = 1'b1;
          end
        end
        ST_GOT_E0F0: begin
          state_d = ST_IDLE;
          if (rx_byte == SC_EXT || rx_byte == SC_BRK) begin
            err_d = 1'b1;
          end else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_brk = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (wd_expire) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_en     <= 1'b0;
      key_code  <= '0;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      key_valid <= 1'b0;
      seq_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_en   <= enable;
      seq_err <= err_d;
      overrun <= 1'b0;
      if (emit) begin
        if (!key_valid || key_ack) begin
          key_code  <= rx_byte;
          key_ext   <= emit_ext;
          key_break <= emit_brk;
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_valid && key_ack) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
module tb_ps2_key_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       key_ack = 1'b0;

  logic       rx_en, key_ext, key_break, key_valid, seq_err, overrun;
  logic [7:0] key_code;
  logic       nf_rx_en, nf_ext, nf_break, nf_valid, nf_err, nf_ovr;
  logic [7:0] nf_code;

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  ps2_key_ctrl #(.TIMEOUT_CYC(16), .FILTER_CTRL(1'b1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rx_done_tick(rx_done_tick),
    .rx_byte(rx_byte), .rx_en(rx_en), .key_code(key_code), .key_ext(key_ext),
    .key_break(key_break), .key_valid(key_valid), .key_ack(key_ack),
    .seq_err(seq_err), .overrun(overrun)
  );

  ps2_key_ctrl #(.TIMEOUT_CYC(16), .FILTER_CTRL(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .enable(enable), .rx_done_tick(rx_done_tick),
    .rx_byte(rx_byte), .rx_en(nf_rx_en), .key_code(nf_code), .key_ext(nf_ext),
    .key_break(nf_break), .key_valid(nf_valid), .key_ack(key_ack),
    .seq_err(nf_err), .overrun(nf_ovr)
  );

  typedef struct {
    logic       tick;
    logic [7:0] data;
    logic       ack;
    logic       valid;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       err;
    logic       ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic tick, input logic [7:0] data, input logic ack,
                     input logic valid, input logic [7:0] code, input logic ext,
                     input logic brk, input logic err, input logic ovr);
    vec_t v;
    v.tick = tick; v.data = data; v.ack = ack; v.valid = valid; v.code = code;
    v.ext = ext; v.brk = brk; v.err = err; v.ovr = ovr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample point is 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic tick, input logic [7:0] data, input logic ack);
    rx_done_tick = tick;
    rx_byte      = data;
    key_ack      = ack;
  endtask

  function automatic logic [12:0] outs();
    return {key_valid, key_code, key_ext, key_break, seq_err, overrun};
  endfunction

  initial begin
    //   tick data   ack  valid code   ext brk err ovr
    add(1, 8'h1C, 0,   1, 8'h1C, 0, 0, 0, 0);  // plain make
    add(0, 8'h00, 1,   0, 8'h1C, 0, 0, 0, 0);  // ack clears valid
    add(1, 8'hE0, 0,   0, 8'h1C, 0, 0, 0, 0);  // prefix: no event
    add(0, 8'h00, 0,   0, 8'h1C, 0, 0, 0, 0);
    add(1, 8'hF0, 0,   0, 8'h1C, 0, 0, 0, 0);
    add(1, 8'h75, 0,   1, 8'h75, 1, 1, 0, 0);  // extended break
    add(0, 8'h00, 1,   0, 8'h75, 1, 1, 0, 0);
    add(1, 8'hF0, 0,   0, 8'h75, 1, 1, 0, 0);
    add(1, 8'hF0, 0,   0, 8'h75, 1, 1, 1, 0);  // F0 F0 protocol error
    add(0, 8'h00, 0,   0, 8'h75, 1, 1, 0, 0);  // single-cycle pulse
    add(1, 8'hAA, 0,   0, 8'h75, 1, 1, 0, 0);  // filtered
    add(1, 8'h1C, 0,   1, 8'h1C, 0, 0, 0, 0);
    add(1, 8'h32, 0,   1, 8'h1C, 0, 0, 0, 1);  // overrun, held event kept
    add(0, 8'h00, 0,   1, 8'h1C, 0, 0, 0, 0);
    add(1, 8'h32, 1,   1, 8'h32, 0, 0, 0, 0);  // emit with ack: no bubble
    add(0, 8'h00, 1,   0, 8'h32, 0, 0, 0, 0);
    add(1, 8'hE0, 0,   0, 8'h32, 0, 0, 0, 0);
    add(1, 8'h74, 0,   1, 8'h74, 1, 0, 0, 0);  // extended make
    add(0, 8'h00, 1,   0, 8'h74, 1, 0, 0, 0);
    add(1, 8'h1C, 0,   1, 8'h1C, 0, 0, 0, 0);
    add(1, 8'hF0, 0,   1, 8'h1C, 0, 0, 0, 0);
    add(1, 8'hE0, 0,   1, 8'h1C, 0, 0, 1, 0);  // F0 E0 error
    add(1, 8'hE0, 0,   1, 8'h1C, 0, 0, 0, 0);
    add(1, 8'hE0, 0,   1, 8'h1C, 0, 0, 0, 0);  // duplicate E0 tolerated
    add(1, 8'h11, 0,   1, 8'h1C, 0, 0, 0, 1);  // ext event overruns
    add(0, 8'h00, 1,   0, 8'h1C, 0, 0, 0, 0);
    add(1, 8'hE0, 0,   0, 8'h1C, 0, 0, 0, 0);
    add(1, 8'hF0, 0,   0, 8'h1C, 0, 0, 0, 0);
    add(1, 8'hF0, 0,   0, 8'h1C, 0, 0, 1, 0);  // E0 F0 F0 error
    add(0, 8'h00, 0,   0, 8'h1C, 0, 0, 0, 0);
    add(1, 8'hFA, 0,   0, 8'h1C, 0, 0, 0, 0);
    add(1, 8'hEE, 0,   0, 8'h1C, 0, 0, 0, 0);
    add(1, 8'hFE, 0,   0, 8'h1C, 0, 0, 0, 0);
    add(1, 8'h00, 0,   0, 8'h1C, 0, 0, 0, 0);
    add(1, 8'hFF, 0,   0, 8'h1C, 0, 0, 0, 0);

    // Reset state
    step(); step();
    check("reset_outs", {19'd0, outs()}, 32'd0);
    check("reset_rx_en", {31'd0, rx_en}, 32'd0);
    reset = 1'b1;
    enable = 1'b1;
    step();
    check("rx_en_follows", {31'd0, rx_en}, 32'd1);

    foreach (vecs[i]) begin
      drive(vecs[i].tick, vecs[i].data, vecs[i].ack);
      step();
      check($sformatf("row%0d", i), {19'd0, outs()},
            {19'd0, vecs[i].valid, vecs[i].code, vecs[i].ext, vecs[i].brk,
             vecs[i].err, vecs[i].ovr});
    end
    drive(0, 8'h00, 0);

    // Watchdog timeout: F0 then silence
    drive(1, 8'hF0, 0); step(); drive(0, 8'h00, 0);
    for (int k = 1; k <= 15; k++) begin
      step();
      check($sformatf("to_wait%0d", k), {31'd0, seq_err}, 32'd0);
    end
    step();
    check("to_err", {19'd0, outs()}, {19'd0, 1'b0, 8'h1C, 1'b0, 1'b0, 1'b1, 1'b0});
    step();
    check("to_err_end", {31'd0, seq_err}, 32'd0);
    drive(1, 8'h1C, 0); step(); drive(0, 8'h00, 0);
    check("to_then_make", {19'd0, outs()}, {19'd0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0});
    drive(0, 8'h00, 1); step(); drive(0, 8'h00, 0);

    // Tick in the expiry cycle wins
    drive(1, 8'hF0, 0); step(); drive(0, 8'h00, 0);
    for (int k = 1; k <= 15; k++) step();
    drive(1, 8'h75, 0); step(); drive(0, 8'h00, 0);
    check("tick_wins", {19'd0, outs()}, {19'd0, 1'b1, 8'h75, 1'b0, 1'b1, 1'b0, 1'b0});
    step();
    check("tick_wins_noerr", {31'd0, seq_err}, 32'd0);
    drive(0, 8'h00, 1); step(); drive(0, 8'h00, 0);

    // Filter disabled instance emits AA
    reset = 1'b0; #2; reset = 1'b1;
    step();
    drive(1, 8'hAA, 0); step(); drive(0, 8'h00, 0);
    check("filt_on_aa", {31'd0, key_valid}, 32'd0);
    check("filt_off_aa", {23'd0, nf_valid, nf_code}, {23'd0, 1'b1, 8'hAA});

    // Mid-sequence reset drops the prefix
    drive(0, 8'h00, 1); step(); drive(0, 8'h00, 0);
    drive(1, 8'h75, 0); step(); drive(0, 8'h00, 0);
    check("pre_rst_event", {23'd0, key_valid, key_code}, {23'd0, 1'b1, 8'h75});
    drive(1, 8'hE0, 1); step(); drive(0, 8'h00, 0);
    reset = 1'b0; #1;
    check("midseq_rst_outs", {19'd0, outs()}, 32'd0);
    check("midseq_rst_rx_en", {31'd0, rx_en}, 32'd0);
    reset = 1'b1;
    drive(1, 8'h75, 0); step(); drive(0, 8'h00, 0);
    check("post_rst_make", {19'd0, outs()}, {19'd0, 1'b1, 8'h75, 1'b0, 1'b0, 1'b0, 1'b0});
    drive(0, 8'h00, 1); step(); drive(0, 8'h00, 0);

    // Enable drop: rx_en lags by one cycle, ticks ignored, FSM forced idle
    drive(1, 8'hE0, 0); step(); drive(0, 8'h00, 0);
    enable = 1'b0;
    check("en_lag", {31'd0, rx_en}, 32'd1);
    step();
    check("en_off_rx_en", {31'd0, rx_en}, 32'd0);
    drive(1, 8'h1C, 0); step(); drive(0, 8'h00, 0);
    check("en_off_ignored", {31'd0, key_valid}, 32'd0);
    enable = 1'b1;
    drive(1, 8'h1C, 0); step(); drive(0, 8'h00, 0);
    check("en_forced_idle", {19'd0, outs()}, {19'd0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
